// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite encodings, data-phase state type and transfer decode helpers
// for the SRAM responder.
package ahbl_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    typedef enum logic [1:0] {
        DP_IDLE,
        DP_RD,
        DP_ERR1,
        DP_ERR2
    } dp_state_t;

    function automatic logic trans_active(input logic [1:0] htrans);
        trans_active = 1'b0;
        case (htrans)
            HTRANS_NONSEQ, HTRANS_SEQ: trans_active = 1'b1;
            HTRANS_IDLE, HTRANS_BUSY:  trans_active = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] hsize, input logic [1:0] lane);
        case (hsize)
            HSIZE_BYTE: byte_en = 4'b0001 << lane;
            HSIZE_HALF: byte_en = 4'b0011 << lane;
            default:    byte_en = 4'hF;
        endcase
    endfunction

    // Wider than a word, or a halfword/word that is not naturally aligned.
    function automatic logic size_illegal(input logic [2:0] hsize, input logic [1:0] lane);
        size_illegal = (hsize > HSIZE_WORD)
                     || ((hsize == HSIZE_HALF) && lane[0])
                     || ((hsize == HSIZE_WORD) && (lane != 2'b00));
    endfunction

endpackage

// File: rtl/ahbl_sram_wbuf.sv
// One-entry posted write buffer: captures write address/data phases, drains to
// the SRAM in read-free cycles and merges pending bytes into read data.
module ahbl_sram_wbuf
    import ahbl_pkg::*;
#(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  cpu_clk,
    input  logic                  pg_reset_b,
    input  logic                  wr_acc,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [3:0]            wr_be,
    input  logic [31:0]           hwdata,
    input  logic                  rd_acc,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [31:0]           sram_rdata,
    output logic                  drain,
    output logic                  wb_vld,
    output logic [ADDR_WIDTH-1:0] wb_addr,
    output logic [3:0]            wb_be,
    output logic [31:0]           wb_data,
    output logic [31:0]           fwd_rdata
);

    logic                  load_p1;
    logic [ADDR_WIDTH-1:0] pend_addr_p1;
    logic [3:0]            pend_be_p1;
    logic                  fwd_hit;

    assign drain   = wb_vld && !rd_acc;
    assign fwd_hit = wb_vld && (wb_addr == rd_addr);

    always_ff @(posedge cpu_clk or negedge pg_reset_b) begin
        if (!pg_reset_b) begin
            load_p1 <= 1'b0;
            wb_vld  <= 1'b0;
        end else begin
            load_p1 <= wr_acc;
            // A reload on the same edge as a drain keeps the entry valid.
            if (load_p1)
                wb_vld <= 1'b1;
            else if (drain)
                wb_vld <= 1'b0;
        end
    end

    // Address/lanes wait in a pending stage so a back-to-back write address
    // phase cannot overwrite the entry whose data phase is still in flight.
    always_ff @(posedge cpu_clk) begin
        if (wr_acc) begin
            pend_addr_p1 <= wr_addr;
            pend_be_p1   <= wr_be;
        end
        if (load_p1) begin
            wb_addr <= pend_addr_p1;
            wb_be   <= pend_be_p1;
            wb_data <= hwdata;
        end
    end

    always_comb begin
        fwd_rdata = sram_rdata;
        for (int b = 0; b < 4; b++) begin
            if (fwd_hit && wb_be[b])
                fwd_rdata[8*b +: 8] = wb_data[8*b +: 8];
        end
    end

endmodule

// File: rtl/ahbl_sram_slave.sv
// AHB-Lite responder onto a single-port synchronous SRAM: zero-wait posted
// writes, configurable read wait states, two-cycle ERROR for illegal sizes.
module ahbl_sram_slave
    import ahbl_pkg::*;
#(
    parameter int ADDR_WIDTH = 14,
    parameter int RD_WAIT    = 0
) (
    input  logic                  cpu_clk,
    input  logic                  pg_reset_b,
    input  logic                  biu_pad_hsel,
    input  logic [31:0]           biu_pad_haddr,
    input  logic [1:0]            biu_pad_htrans,
    input  logic [2:0]            biu_pad_hsize,
    input  logic                  biu_pad_hwrite,
    input  logic [2:0]            biu_pad_hburst,
    input  logic [3:0]            biu_pad_hprot,
    input  logic [31:0]           biu_pad_hwdata,
    output logic [31:0]           pad_biu_hrdata,
    output logic                  pad_biu_hready,
    output logic                  pad_biu_hresp,
    output logic                  sram_cen,
    output logic                  sram_wen,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [3:0]            sram_be,
    output logic [31:0]           sram_wdata,
    input  logic [31:0]           sram_rdata
);

    dp_state_t             state;
    logic                  hready_q;
    logic                  hresp_q;
    logic [1:0]            wait_cnt;
    logic                  rd_first_p1;
    logic [ADDR_WIDTH-1:0] rd_addr_p1;
    logic [31:0]           hrdata_hold;

    logic                  accept, illegal, rd_acc, wr_acc, err_acc;
    logic [ADDR_WIDTH-1:0] haddr_word;
    logic                  drain, wb_vld;
    logic [ADDR_WIDTH-1:0] wb_addr;
    logic [3:0]            wb_be;
    logic [31:0]           wb_data, fwd_rdata;
    logic                  unused_ok;

    assign unused_ok  = ^{biu_pad_hburst, biu_pad_hprot, biu_pad_haddr[31:ADDR_WIDTH+2]};
    assign haddr_word = biu_pad_haddr[ADDR_WIDTH+1:2];
    assign accept     = biu_pad_hsel && trans_active(biu_pad_htrans) && hready_q;
    assign illegal    = size_illegal(biu_pad_hsize, biu_pad_haddr[1:0]);
    assign rd_acc     = accept && !illegal && !biu_pad_hwrite;
    assign wr_acc     = accept && !illegal && biu_pad_hwrite;
    assign err_acc    = accept && illegal;

    ahbl_sram_wbuf #(.ADDR_WIDTH(ADDR_WIDTH)) u_wbuf (
        .cpu_clk    (cpu_clk),
        .pg_reset_b (pg_reset_b),
        .wr_acc     (wr_acc),
        .wr_addr    (haddr_word),
        .wr_be      (byte_en(biu_pad_hsize, biu_pad_haddr[1:0])),
        .hwdata     (biu_pad_hwdata),
        .rd_acc     (rd_acc),
        .rd_addr    (rd_addr_p1),
        .sram_rdata (sram_rdata),
        .drain      (drain),
        .wb_vld     (wb_vld),
        .wb_addr    (wb_addr),
        .wb_be      (wb_be),
        .wb_data    (wb_data),
        .fwd_rdata  (fwd_rdata)
    );

    // Reads own the SRAM port in their address phase; otherwise the buffer drains.
    assign sram_cen   = rd_acc || wb_vld;
    assign sram_wen   = drain;
    assign sram_addr  = rd_acc ? haddr_word : wb_addr;
    assign sram_be    = drain ? wb_be : 4'h0;
    assign sram_wdata = wb_data;

    assign pad_biu_hready = hready_q;
    assign pad_biu_hresp  = hresp_q;
    assign pad_biu_hrdata = rd_first_p1 ? fwd_rdata : hrdata_hold;

    always_ff @(posedge cpu_clk) begin
        if (rd_acc)
            rd_addr_p1 <= haddr_word;
    end

    always_ff @(posedge cpu_clk or negedge pg_reset_b) begin
        if (!pg_reset_b) begin
            state       <= DP_IDLE;
            hready_q    <= 1'b1;
            hresp_q     <= 1'b0;
            wait_cnt    <= 2'd0;
            rd_first_p1 <= 1'b0;
            hrdata_hold <= 32'h0;
        end else begin
            rd_first_p1 <= rd_acc;
            if (rd_first_p1)
                hrdata_hold <= fwd_rdata;
            // hready high closes the current data phase; pick the next one.
            if (hready_q) begin
                if (err_acc) begin
                    state    <= DP_ERR1;
                    hready_q <= 1'b0;
                    hresp_q  <= 1'b1;
                end else if (rd_acc && (RD_WAIT > 0)) begin
                    state    <= DP_RD;
                    hready_q <= 1'b0;
                    hresp_q  <= 1'b0;
                    wait_cnt <= 2'(RD_WAIT - 1);
                end else begin
                    state    <= DP_IDLE;
                    hready_q <= 1'b1;
                    hresp_q  <= 1'b0;
                end
            end else begin
                case (state)
                    DP_ERR1: begin
                        state    <= DP_ERR2;
                        hready_q <= 1'b1;
                    end
                    DP_RD: begin
                        if (wait_cnt == 2'd0)
                            hready_q <= 1'b1;
                        else
                            wait_cnt <= wait_cnt - 2'd1;
                    end
                    default: begin
                        state    <= DP_IDLE;
                        hready_q <= 1'b1;
                        hresp_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/ahbl_sram_slave.md
# ahbl_sram_slave

AHB-Lite responder that terminates the CPU subsystem's data-bus master port (biu_pad_* / pad_biu_*) onto a single-port synchronous SRAM macro. Zero-wait-state writes through a one-entry posted write buffer with read forwarding, configurable read wait states, and a two-cycle ERROR response for illegal transfers. Sits between the E902 data AHB-Lite port and the on-chip data SRAM.

## Interface
- ADDR_WIDTH, 14: SRAM word-address bits (64 KB).
- RD_WAIT, 0: extra wait cycles per read data phase (0..3).
- cpu_clk  in  1  bus and SRAM clock.
- pg_reset_b  in  1  reset; asynchronous, active-low.
- biu_pad_hsel  in  1  slave select from address decode.
- biu_pad_haddr  in  32  address.
- biu_pad_htrans  in  2  IDLE/BUSY/NONSEQ/SEQ.
- biu_pad_hsize  in  3  transfer size.
- biu_pad_hwrite  in  1  1 = write.
- biu_pad_hburst, biu_pad_hprot  in  3, 4  ignored.
- biu_pad_hwdata  in  32  write data (data phase).
- pad_biu_hrdata  out  32  read data.
- pad_biu_hready  out  1  transfer done / slave ready.
- pad_biu_hresp  out  1  0 OKAY, 1 ERROR.
- sram_cen  out  1  chip enable, active high.
- sram_wen  out  1  write enable, active high.
- sram_addr  out  ADDR_WIDTH  word address.
- sram_be  out  4  byte-lane write enable.
- sram_wdata  out  32  write data.
- sram_rdata  in  32  read data, valid one cycle after read cen.

## Operation
- Accept: hsel & htrans[1] & pad_biu_hready at rising edge. BUSY/IDLE: OKAY, no access. Bursts handled as individual transfers. Little-endian only.
- Illegal: hsize > 2, halfword with haddr[0]=1, word with haddr[1:0]!=0. Response ERROR: cycle 1 hready=0 hresp=1, cycle 2 hready=1 hresp=1. No SRAM access, no buffer load.
- Byte enables: byte 4'b0001<<haddr[1:0]; half 4'b0011<<haddr[1:0]; word 4'hF.
- Read: sram_cen=1, wen=0, sram_addr=haddr[ADDR_WIDTH+1:2] combinationally in the accepted address-phase cycle. First data-phase cycle captures merged word into hrdata hold register.
- Write buffer (wb_vld, wb_addr, wb_be, wb_data): write address phase latches addr/be; end of write data phase loads hwdata, sets wb_vld.
- Drain: in any cycle with wb_vld and no accepted read address phase, drive SRAM write from buffer, clear wb_vld at edge (unless reloaded same edge). Every write address-phase cycle is read-free, so buffer is empty before reload; writes never stall.
- Forwarding: in read data phase, if wb_vld & wb_addr==read word addr, lanes with wb_be take wb_data, others sram_rdata.
- FSM (data-phase state): IDLE → RD (read accepted, RD_WAIT>0) / ERR1 (illegal accepted). RD counts RD_WAIT cycles hready=0, then hready=1 → IDLE or next. ERR1 → ERR2 → IDLE. With RD_WAIT=0 reads complete in IDLE with hready=1.
- Reset mid-operation: FSM to IDLE, buffered write discarded.

## Timing
- Reset values: pad_biu_hready=1, pad_biu_hresp=0, pad_biu_hrdata=0, sram_cen=0, sram_wen=0, wb_vld=0.
- Write: address phase N, data phase N+1 with hready=1; SRAM written at N+2 or first later read-free cycle.
- Read: address N, data N+1+RD_WAIT; hready low for RD_WAIT cycles.
- Write data phase concurrent with read address phase to same word: read returns forwarded new bytes.
- hresp=0 whenever hready=1 except ERR2.

## Structure
- Package ahbl_pkg: HTRANS_IDLE/BUSY/NONSEQ/SEQ, HSIZE_BYTE/HALF/WORD, data-phase state enum (IDLE, RD, ERR1, ERR2), byte-enable function.
- Sub-module ahbl_sram_wbuf: buffer regs, drain control, forwarding merge.

## Test plan
- Word write 0x100←0xDEADBEEF, idle, read 0x100 → hrdata 0xDEADBEEF, hready never low (RD_WAIT=0).
- Byte write 0x102←0x55 then back-to-back word read 0x100 (old 0x11223344) → 0x11553344 via forwarding, single SRAM read.
- 20 consecutive reads after a write: buffer holds until next write address phase; final SRAM word correct.
- Word access at 0x101 → hready 0 hresp 1, then hready 1 hresp 1; sram_cen stays 0.
- RD_WAIT=2 read → hready low exactly 2 cycles, data valid on third data-phase cycle.
- pg_reset_b low while wb_vld=1 → all outputs reset values, buffered write never reaches SRAM.
